// File: rtl/matrix_pkg.sv
// Shared constants, FSM state encoding and RGB field layout for the HUB75 capture path.
package matrix_pkg;
  localparam int NUM_COLS   = 64;
  localparam int NUM_ROWS   = 16;
  localparam int NUM_PLANES = 6;
  localparam int ROW_W      = $clog2(NUM_ROWS);
  localparam int COL_W      = $clog2(NUM_COLS);
  localparam int PLANE_W    = $clog2(NUM_PLANES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_EMIT
  } state_t;

  // hub_rgb bit order: upper half in [5:3], lower half in [2:0]
  typedef struct packed {
    logic b1;
    logic g1;
    logic r1;
    logic b0;
    logic g0;
    logic r0;
  } rgb6_t;

  // Plane k is counted once OE width reaches 3/4 of its nominal BASE<<k.
  function automatic logic [PLANE_W-1:0] plane_of(input int unsigned w, input int unsigned base);
    logic [PLANE_W-1:0] p;
    p = '0;
    for (int k = 1; k < NUM_PLANES; k++)
      if (w >= ((3 * base) << k) / 4) p = p + 1'b1;
    return p;
  endfunction
endpackage

// File: rtl/hub75_input_sync.sv
// 2-FF synchroniser for the HUB75 bus; emits registered edge pulses with row/rgb kept aligned.
module hub75_input_sync #(
  parameter bit OE_ACT_HIGH = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       hub_clk,
  input  logic       hub_lat,
  input  logic       hub_oe,
  input  logic [3:0] hub_row,
  input  logic [5:0] hub_rgb,
  output logic       clk_rise,
  output logic       lat_rise,
  output logic       oe_rise,
  output logic       oe_fall,
  output logic       oe_on,
  output logic [3:0] row,
  output logic [5:0] rgb
);
  logic       oe_in;
  logic [2:0] s1, s2, s3;
  logic [9:0] d1, d2;

  // normalise OE polarity before the synchroniser so everything downstream is active-high
  assign oe_in = OE_ACT_HIGH ? hub_oe : ~hub_oe;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      d1       <= '0;
      d2       <= '0;
      clk_rise <= 1'b0;
      lat_rise <= 1'b0;
      oe_rise  <= 1'b0;
      oe_fall  <= 1'b0;
      oe_on    <= 1'b0;
      row      <= '0;
      rgb      <= '0;
    end else begin
      s1       <= {hub_clk, hub_lat, oe_in};
      s2       <= s1;
      s3       <= s2;
      d1       <= {hub_row, hub_rgb};
      d2       <= d1;
      clk_rise <= s2[2] & ~s3[2];
      lat_rise <= s2[1] & ~s3[1];
      oe_rise  <= s2[0] & ~s3[0];
      oe_fall  <= ~s2[0] & s3[0];
      oe_on    <= s2[0];
      row      <= d2[9:6];
      rgb      <= d2[5:0];
    end
  end
endmodule

// File: rtl/matrix_capture.sv
// HUB75 receive monitor: rebuilds (row, col, plane, rgb) pixel words from the panel bus.
// Optional MATRIX_CAPTURE_STATS_EN adds stat_lines / stat_frames counters.
module matrix_capture
  import matrix_pkg::*;
#(
  parameter int          COLS        = NUM_COLS,
  parameter int unsigned BASE_CYCLES = 23,
  parameter bit          OE_ACT_HIGH = 1'b1,
  parameter int          WIDTH_W     = 10
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        hub_clk,
  input  logic        hub_lat,
  input  logic        hub_oe,
  input  logic [3:0]  hub_row,
  input  logic [5:0]  hub_rgb,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [3:0]  px_row,
  output logic [5:0]  px_col,
  output logic [2:0]  px_plane,
  output logic [5:0]  px_rgb,
  output logic        err_count,
  output logic        err_overrun,
  output logic        err_plane
`ifdef MATRIX_CAPTURE_STATS_EN
  ,
  output logic [15:0] stat_lines,
  output logic [15:0] stat_frames
`endif
);
  logic               clk_rise, lat_rise, oe_rise, oe_fall, oe_on;
  logic [3:0]         s_row;
  logic [5:0]         s_rgb;
  state_t             state, state_nxt;
  logic [COLS-1:0][5:0] shreg, linebuf;
  logic [6:0]         sh_cnt;
  logic [3:0]         line_row;
  logic [WIDTH_W-1:0] width;
  logic [2:0]         plane_q, plane_cls;
  logic [5:0]         col;
  logic               hs, last_hs, lat_take, too_short;

  hub75_input_sync #(.OE_ACT_HIGH(OE_ACT_HIGH)) u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .hub_clk  (hub_clk),
    .hub_lat  (hub_lat),
    .hub_oe   (hub_oe),
    .hub_row  (hub_row),
    .hub_rgb  (hub_rgb),
    .clk_rise (clk_rise),
    .lat_rise (lat_rise),
    .oe_rise  (oe_rise),
    .oe_fall  (oe_fall),
    .oe_on    (oe_on),
    .row      (s_row),
    .rgb      (s_rgb)
  );

  assign hs        = (state == ST_EMIT) && px_ready;
  assign last_hs   = hs && (col == 6'(COLS - 1));
  // a latch on the very cycle the last word is accepted is a clean handover, not an overrun
  assign lat_take  = lat_rise && ((state == ST_IDLE) || (state == ST_ARMED) || last_hs);
  assign too_short = 32'(width) < (BASE_CYCLES / 2);
  assign plane_cls = plane_of(32'(width), BASE_CYCLES);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (lat_rise) state_nxt = ST_ARMED;
      ST_ARMED:   if (oe_rise)  state_nxt = ST_MEASURE;
      ST_MEASURE: if (oe_fall)  state_nxt = too_short ? ST_IDLE : ST_EMIT;
      ST_EMIT:    if (last_hs)  state_nxt = lat_rise ? ST_ARMED : ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    px_valid = (state == ST_EMIT);
    px_row   = '0;
    px_col   = '0;
    px_plane = '0;
    px_rgb   = '0;
    if (px_valid) begin
      px_row   = line_row;
      px_col   = col;
      px_plane = plane_q;
      px_rgb   = linebuf[col];
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      linebuf     <= '0;
      sh_cnt      <= '0;
      line_row    <= '0;
      width       <= '0;
      plane_q     <= '0;
      col         <= '0;
      err_count   <= 1'b0;
      err_overrun <= 1'b0;
      err_plane   <= 1'b0;
    end else begin
      // newest pixel enters at index 0, so after a full line index == column
      if (clk_rise) begin
        shreg <= {shreg[COLS-2:0], s_rgb};
        if (sh_cnt != 7'(COLS + 1)) sh_cnt <= sh_cnt + 7'd1;
      end
      if (lat_rise) begin
        sh_cnt <= '0;
        if (lat_take) begin
          linebuf  <= shreg;
          line_row <= s_row;
          if (sh_cnt != 7'(COLS)) err_count <= 1'b1;
        end else begin
          err_overrun <= 1'b1;
        end
      end
      if ((state == ST_ARMED) && oe_rise)
        width <= WIDTH_W'(1);
      else if ((state == ST_MEASURE) && !oe_fall && oe_on && (width != '1))
        width <= width + 1'b1;
      if ((state == ST_MEASURE) && oe_fall) begin
        plane_q <= plane_cls;
        col     <= '0;
        if (too_short) err_plane <= 1'b1;
      end
      if (hs) col <= col + 6'd1;
    end
  end

`ifdef MATRIX_CAPTURE_STATS_EN
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      stat_lines  <= '0;
      stat_frames <= '0;
    end else if (last_hs) begin
      stat_lines <= stat_lines + 16'd1;
      if ((line_row == 4'd0) && (plane_q == 3'd5)) stat_frames <= stat_frames + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_matrix_capture.sv
// Bench for matrix_capture: drives HUB75 lines, scoreboards emitted pixel words.
module tb_matrix_capture;
  logic       clk_in = 1'b0;
  logic       reset;
  logic       hub_clk, hub_lat, hub_oe;
  logic [3:0] hub_row;
  logic [5:0] hub_rgb;
  logic       px_valid, px_ready;
  logic [3:0] px_row;
  logic [5:0] px_col;
  logic [2:0] px_plane;
  logic [5:0] px_rgb;
  logic       err_count, err_overrun, err_plane;
`ifdef MATRIX_CAPTURE_STATS_EN
  logic [15:0] stat_lines, stat_frames;
`endif

  matrix_capture dut (
    .clk_in(clk_in), .reset(reset), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_row(hub_row), .hub_rgb(hub_rgb), .px_valid(px_valid), .px_ready(px_ready),
    .px_row(px_row), .px_col(px_col), .px_plane(px_plane), .px_rgb(px_rgb),
    .err_count(err_count), .err_overrun(err_overrun), .err_plane(err_plane)
`ifdef MATRIX_CAPTURE_STATS_EN
    , .stat_lines(stat_lines), .stat_frames(stat_frames)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] col;
    logic [2:0] plane;
    logic [5:0] rgb;
  } word_t;

  typedef struct {
    int width;
    int seed;
    int row;
    int plane;
    int emit;
  } vec_t;

  word_t      q[$];
  logic [5:0] model_sr[64];
  int         total = 0;
  int         bad = 0;
  int         pops = 0;
  int         ready_mode = 0;
  int         rcnt = 0;
  vec_t       vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic hub_shift(input logic [5:0] v);
    hub_rgb = v;
    hub_clk = 1'b0;
    tick(2);
    hub_clk = 1'b1;
    tick(2);
    hub_clk = 1'b0;
    for (int i = 63; i > 0; i--) model_sr[i] = model_sr[i-1];
    model_sr[0] = v;
  endtask

  task automatic shift_line(input int n, input int seed);
    for (int i = 0; i < n; i++) hub_shift(6'(i ^ seed));
  endtask

  task automatic latch(input int row);
    hub_row = 4'(row);
    tick(1);
    hub_lat = 1'b1;
    tick(2);
    hub_lat = 1'b0;
    tick(4);
  endtask

  task automatic oe_pulse(input int n);
    hub_oe = 1'b1;
    tick(n);
    hub_oe = 1'b0;
  endtask

  task automatic push_line(input int row, input int plane);
    for (int c = 0; c < 64; c++) q.push_back({4'(row), 6'(c), 3'(plane), model_sr[c]});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() > 0 && n < 3000) begin
      tick(1);
      n++;
    end
    check("drain_left", q.size(), 0);
    tick(8);
  endtask

  // consumer backpressure
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      rcnt++;
      px_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
    end
  end

  // output monitor: scoreboard pop plus hold-stability under backpressure
  initial begin
    logic  held;
    word_t held_w, act, exp;
    held = 1'b0;
    held_w = '0;
    forever begin
      @(negedge clk_in);
      act = {px_row, px_col, px_plane, px_rgb};
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) check("hold_stable", int'(act), int'(held_w));
        if (px_valid && px_ready) begin
          if (q.size() == 0) check("unexpected_word", 1, 0);
          else begin
            exp = q.pop_front();
            check($sformatf("word_c%0d", exp.col), int'(act), int'(exp));
            pops++;
          end
        end
        held = px_valid && !px_ready;
        held_w = act;
      end
    end
  end

  initial begin
    int base, n;
    reset = 1'b1;
    hub_clk = 1'b0;
    hub_lat = 1'b0;
    hub_oe = 1'b0;
    hub_row = '0;
    hub_rgb = '0;
    for (int i = 0; i < 64; i++) model_sr[i] = '0;

    vecs[0] = '{23, 0, 5, 0, 1};
    vecs[1] = '{46, 7, 1, 1, 1};
    vecs[2] = '{92, 21, 2, 2, 1};
    vecs[3] = '{184, 42, 3, 3, 1};
    vecs[4] = '{368, 13, 0, 4, 1};
    vecs[5] = '{736, 55, 0, 5, 1};
    vecs[6] = '{8, 9, 4, 0, 0};

    tick(3);
    check("rst_valid", px_valid, 0);
    check("rst_word", int'({px_row, px_col, px_plane, px_rgb}), 0);
    check("rst_errs", int'({err_count, err_overrun, err_plane}), 0);
    reset = 1'b0;
    tick(3);

    foreach (vecs[i]) begin
      base = pops;
      shift_line(64, vecs[i].seed);
      latch(vecs[i].row);
      if (vecs[i].emit != 0) push_line(vecs[i].row, vecs[i].plane);
      oe_pulse(vecs[i].width);
      wait_drain();
      check($sformatf("v%0d_words", i), pops - base, vecs[i].emit != 0 ? 64 : 0);
      check($sformatf("v%0d_err_plane", i), err_plane, vecs[i].emit != 0 ? 0 : 1);
      check($sformatf("v%0d_err_count", i), err_count, 0);
    end

    // short line: flagged but still emitted
    base = pops;
    shift_line(63, 3);
    latch(6);
    push_line(6, 0);
    oe_pulse(23);
    wait_drain();
    check("short_err_count", err_count, 1);
    check("short_words", pops - base, 64);

    // backpressure 1-in-3
    base = pops;
    ready_mode = 1;
    shift_line(64, 33);
    latch(7);
    push_line(7, 0);
    oe_pulse(23);
    wait_drain();
    ready_mode = 0;
    check("bp_words", pops - base, 64);

    // second latch mid-emission is dropped
    base = pops;
    shift_line(64, 17);
    latch(8);
    push_line(8, 0);
    oe_pulse(23);
    n = 0;
    while (!px_valid && n < 200) begin
      tick(1);
      n++;
    end
    check("ovr_emit_started", px_valid, 1);
    latch(9);
    wait_drain();
    check("ovr_err_overrun", err_overrun, 1);
    oe_pulse(23);
    tick(100);
    check("ovr_words", pops - base, 64);

    // reset in the middle of a line
    shift_line(64, 5);
    latch(10);
    push_line(10, 0);
    base = pops;
    oe_pulse(23);
    n = 0;
    while (pops < base + 30 && n < 500) begin
      tick(1);
      n++;
    end
    check("rst_mid_reached", pops - base, 30);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", px_valid, 0);
    check("rst_mid_errs", int'({err_count, err_overrun, err_plane}), 0);
    q.delete();
    tick(2);
    reset = 1'b0;
    tick(2);

    base = pops;
    shift_line(64, 40);
    latch(11);
    push_line(11, 2);
    oe_pulse(92);
    wait_drain();
    check("post_rst_words", pops - base, 64);
    check("post_rst_errs", int'({err_count, err_overrun, err_plane}), 0);
`ifdef MATRIX_CAPTURE_STATS_EN
    check("stat_lines", int'(stat_lines), 1);
    check("stat_frames", int'(stat_frames), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
